// File: rtl/disp_feed.sv
// ============================================================================
// disp_feed : scan clock divider, debounced source stepping and frame-aligned
//             latch of the selected debug value for the 7-segment scanner.
// Rev 1.0
// ============================================================================
`default_nettype none

module disp_feed #(
  parameter int DIV_HALF   = 25000,
  parameter int DEB_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] src0,
  input  logic [11:0] src1,
  input  logic [11:0] src2,
  input  logic [11:0] src3,
  input  logic        btn_raw,
  input  logic        freeze,
  output logic        scan_clk,
  output logic [11:0] disp_val,
  output logic [1:0]  src_sel
);

  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             scan_clk_q, scan_clk_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [11:0]      disp_val_q, disp_val_d;
  logic [1:0]       src_sel_q, src_sel_d;
  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  deb_state_t       deb_state_q, deb_state_d;

  logic        w_div_last;
  logic        w_rise;
  logic        w_fall;
  logic [11:0] w_src_mux;

  always_comb begin
    w_div_last = (div_cnt_q == C_DIV_LAST);
    w_rise     = w_div_last & ~scan_clk_q;
    w_fall     = w_div_last &  scan_clk_q;

    div_cnt_d  = w_div_last ? '0 : div_cnt_q + 1'b1;
    scan_clk_d = scan_clk_q ^ w_div_last;

    fcnt_d = fcnt_q;
    if (w_rise) begin
      fcnt_d = (fcnt_q == 2'd2) ? 2'd0 : fcnt_q + 2'd1;
    end

    case (src_sel_q)
      2'd0:    w_src_mux = src0;
      2'd1:    w_src_mux = src1;
      2'd2:    w_src_mux = src2;
      default: w_src_mux = src3;
    endcase

    // Falling edge after the third rising edge: scanner is mid half-period.
    disp_val_d = disp_val_q;
    if (w_fall && (fcnt_q == 2'd0) && !freeze) begin
      disp_val_d = w_src_mux;
    end
  end

  always_comb begin
    deb_state_d = deb_state_q;
    deb_cnt_d   = deb_cnt_q;
    src_sel_d   = src_sel_q;
    case (deb_state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          deb_state_d = WAIT_HI;
          deb_cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          deb_state_d = IDLE_LO;
        end else if (deb_cnt_q == C_DEB_LAST) begin
          deb_state_d = IDLE_HI;
          src_sel_d   = src_sel_q + 2'd1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          deb_state_d = WAIT_LO;
          deb_cnt_d   = '0;
        end
      end
      default: begin
        if (sync2_q) begin
          deb_state_d = IDLE_HI;
        end else if (deb_cnt_q == C_DEB_LAST) begin
          deb_state_d = IDLE_LO;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      scan_clk_q  <= 1'b0;
      fcnt_q      <= 2'd0;
      disp_val_q  <= 12'd0;
      src_sel_q   <= 2'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= '0;
      deb_state_q <= IDLE_LO;
    end else begin
      div_cnt_q   <= div_cnt_d;
      scan_clk_q  <= scan_clk_d;
      fcnt_q      <= fcnt_d;
      disp_val_q  <= disp_val_d;
      src_sel_q   <= src_sel_d;
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_cnt_q   <= deb_cnt_d;
      deb_state_q <= deb_state_d;
    end
  end

  assign scan_clk = scan_clk_q;
  assign disp_val = disp_val_q;
  assign src_sel  = src_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_feed.sv
// ============================================================================
// tb_disp_feed : directed and random stimulus against an edge-count reference.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_disp_feed;

  localparam int DH    = 2;
  localparam int DC    = 4;
  localparam int FRAME = 6 * DH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] srcv [4];
  logic        btn_raw = 1'b0;
  logic        freeze = 1'b0;
  logic        scan_clk;
  logic [11:0] disp_val;
  logic [1:0]  src_sel;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: everything derived from edges since reset and the button run length
  int          m_n;
  int          m_run;
  logic [1:0]  m_sel;
  logic [11:0] m_disp;
  logic        m_lvl, m_s1, m_s2;

  disp_feed #(.DIV_HALF(DH), .DEB_CYCLES(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src0     (srcv[0]),
    .src1     (srcv[1]),
    .src2     (srcv[2]),
    .src3     (srcv[3]),
    .btn_raw  (btn_raw),
    .freeze   (freeze),
    .scan_clk (scan_clk),
    .disp_val (disp_val),
    .src_sel  (src_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_run = 0; m_sel = 2'd0; m_disp = 12'd0;
    m_lvl = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic step();
    logic [11:0] s [4];
    logic fr, b;
    for (int k = 0; k < 4; k++) s[k] = srcv[k];
    fr = freeze;
    b  = btn_raw;
    @(posedge clk);
    m_n++;
    if ((m_n % FRAME) == 0 && !fr) m_disp = s[m_sel];
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == DC + 1) begin
        m_lvl = m_s2;
        m_run = 0;
        if (m_lvl) m_sel = m_sel + 2'd1;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
    #1;
    chk("scan_clk", {11'd0, scan_clk}, 12'((m_n / DH) % 2));
    chk("disp_val", disp_val, m_disp);
    chk("src_sel", {10'd0, src_sel}, {10'd0, m_sel});
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic to_phase(input int ph);
    for (int i = 0; i < FRAME && (m_n % FRAME) != ph; i++) step();
  endtask

  initial begin
    logic [1:0]  start;
    logic [11:0] pre;
    int          hold;
    logic        bounce [11];

    srcv[0] = 12'h123; srcv[1] = 12'h456; srcv[2] = 12'h789; srcv[3] = 12'hABC;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_scan", {11'd0, scan_clk}, 12'd0);
    chk("rst_disp", disp_val, 12'd0);
    chk("rst_sel", {10'd0, src_sel}, 12'd0);
    #10 rst_n = 1'b1;

    // Post-reset timing of scan_clk and the first display update
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 2 || i == 6 || i == 10) chk("scan_rise", {11'd0, scan_clk}, 12'd1);
      if (i == 4 || i == 8 || i == 12) chk("scan_fall", {11'd0, scan_clk}, 12'd0);
      if (i < 12) chk("disp_early", disp_val, 12'h000);
      else        chk("disp_first", disp_val, 12'h123);
    end

    // Clean press: accepted on the 7th edge after the level is applied
    start = m_sel;
    btn_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6) chk("press_wait", {10'd0, src_sel}, {10'd0, start});
      if (i == 7) chk("press_inc", {10'd0, src_sel}, {10'd0, 2'(start + 2'd1)});
    end
    btn_raw = 1'b0;
    steps(10);
    chk("release_hold", {10'd0, src_sel}, {10'd0, 2'(start + 2'd1)});
    step();
    to_phase(0);
    chk("frame_src1", disp_val, srcv[1]);

    // Bouncy press then two clean presses walk back to 0
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      btn_raw = bounce[i];
      step();
    end
    btn_raw = 1'b0;
    steps(10);
    chk("bounce_once", {10'd0, src_sel}, 12'd2);
    for (int p = 0; p < 2; p++) begin
      btn_raw = 1'b1; steps(9);
      btn_raw = 1'b0; steps(9);
    end
    chk("walk_wrap", {10'd0, src_sel}, 12'd0);

    // Freeze holds across frames while src0 keeps changing
    step();
    to_phase(0);
    pre = m_disp;
    freeze = 1'b1;
    for (int f = 0; f < 3; f++) begin
      srcv[0] = (f % 2 == 0) ? 12'h111 : 12'h222;
      steps(FRAME);
      chk("freeze_hold", disp_val, pre);
    end
    freeze = 1'b0;
    steps(FRAME);
    chk("unfreeze", disp_val, srcv[0]);

    // Acceptance lands on the update edge: old source now, new one next frame
    to_phase(FRAME - 7);
    start = m_sel;
    btn_raw = 1'b1;
    steps(7);
    chk("coinc_old", disp_val, srcv[start]);
    chk("coinc_sel", {10'd0, src_sel}, {10'd0, 2'(start + 2'd1)});
    btn_raw = 1'b0;
    steps(FRAME);
    chk("coinc_new", disp_val, srcv[2'(start + 2'd1)]);

    // Asynchronous reset in the middle of WAIT_HI and mid-frame
    btn_raw = 1'b1;
    steps(4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scan", {11'd0, scan_clk}, 12'd0);
    chk("arst_disp", disp_val, 12'd0);
    chk("arst_sel", {10'd0, src_sel}, 12'd0);
    model_reset();
    #3 rst_n = 1'b1;
    steps(6);
    chk("requal_wait", {10'd0, src_sel}, 12'd0);
    step();
    chk("requal_inc", {10'd0, src_sel}, 12'd1);
    btn_raw = 1'b0;
    steps(10);

    // Random sources, freeze and bursty button levels
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) srcv[k] = 12'($urandom);
      freeze = ($urandom_range(0, 3) == 0);
      if (hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
